// File: rtl/mem_b_port_arbiter_if.sv
// Port-B bus bundle shared by the two requesters, the arbiter and the memory.
// The arbiter attaches through the slave modport; the environment drives the master side.
interface mem_b_port_arbiter_if;
  logic        r0_req;
  logic [3:0]  r0_start;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r0_err;

  logic        r1_req;
  logic [3:0]  r1_start;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_lock;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;
  logic        r1_err;

  logic [31:0] mem_addr;
  logic [3:0]  mem_start;
  logic [31:0] mem_write;
  logic [31:0] mem_read;

  modport slave (
    input  r0_req, r0_start, r0_addr, r0_wdata,
    input  r1_req, r1_start, r1_addr, r1_wdata, r1_lock,
    input  mem_read,
    output r0_gnt, r0_rvalid, r0_rdata, r0_err,
    output r1_gnt, r1_rvalid, r1_rdata, r1_err,
    output mem_addr, mem_start, mem_write
  );

  modport master (
    output r0_req, r0_start, r0_addr, r0_wdata,
    output r1_req, r1_start, r1_addr, r1_wdata, r1_lock,
    output mem_read,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
    input  mem_addr, mem_start, mem_write
  );
endinterface

// File: rtl/mem_b_port_arbiter.sv
// Port-B arbiter: round-robin between the LSU (r0) and loader/DMA (r1), bounded burst lock
// for r1, word range check and a registered read/ack return one cycle after each grant.
module mem_b_port_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned MAX_LOCK  = 16
) (
  input logic                 clk,
  input logic                 rst,
  mem_b_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } state_e;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [7:0]  LOCK_MAX  = 8'(MAX_LOCK);

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        r0_rvalid_q, r0_rvalid_d;
  logic [31:0] r0_rdata_q, r0_rdata_d;
  logic        r0_err_q, r0_err_d;
  logic        r1_rvalid_q, r1_rvalid_d;
  logic [31:0] r1_rdata_q, r1_rdata_d;
  logic        r1_err_q, r1_err_d;

  logic        gnt0_s, gnt1_s;
  logic [31:0] sel_addr_s;
  logic        in_range_s;
  logic [3:0]  start_s;

  // Grant selection; nothing is granted while reset is held so no write can land.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.r0_req && bus.r1_req) begin
            gnt0_s = ~rr_ptr_q;
            gnt1_s = rr_ptr_q;
          end else begin
            gnt0_s = bus.r0_req;
            gnt1_s = bus.r1_req;
          end
        end
        LOCK1: begin
          // r0 breaks in only once r1 has used up its lock budget.
          if (bus.r0_req && (!bus.r1_req || (lock_cnt_q == LOCK_MAX))) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = bus.r1_req;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Address/data steering and range gating of the byte strobes.
  always_comb begin
    sel_addr_s = gnt1_s ? bus.r1_addr : bus.r0_addr;
    in_range_s = (sel_addr_s <= LAST_WORD);
    if (gnt0_s) begin
      start_s = bus.r0_start & {4{in_range_s}};
    end else if (gnt1_s) begin
      start_s = bus.r1_start & {4{in_range_s}};
    end else begin
      start_s = 4'h0;
    end
  end

  assign bus.mem_addr  = sel_addr_s;
  assign bus.mem_write = gnt1_s ? bus.r1_wdata : bus.r0_wdata;
  assign bus.mem_start = start_s;
  assign bus.r0_gnt    = gnt0_s;
  assign bus.r1_gnt    = gnt1_s;

  // Next state for the lock FSM, fairness pointer and lock budget counter.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt0_s) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1_s) begin
      rr_ptr_d = 1'b0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      IDLE: begin
        lock_cnt_d = 8'd0;
        if (gnt1_s && bus.r1_lock) begin
          state_d = LOCK1;
        end else begin
          state_d = IDLE;
        end
      end
      LOCK1: begin
        if (gnt0_s || !bus.r1_req || (gnt1_s && !bus.r1_lock)) begin
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
        end else begin
          state_d = LOCK1;
          if (!bus.r0_req) begin
            lock_cnt_d = 8'd0;
          end else if (lock_cnt_q < LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // Return path: capture memory read data at the grant edge; out-of-range reads return zero.
  always_comb begin
    r0_rvalid_d = gnt0_s;
    r1_rvalid_d = gnt1_s;
    if (gnt0_s) begin
      r0_rdata_d = in_range_s ? bus.mem_read : 32'h0000_0000;
      r0_err_d   = ~in_range_s;
    end else begin
      r0_rdata_d = r0_rdata_q;
      r0_err_d   = r0_err_q;
    end
    if (gnt1_s) begin
      r1_rdata_d = in_range_s ? bus.mem_read : 32'h0000_0000;
      r1_err_d   = ~in_range_s;
    end else begin
      r1_rdata_d = r1_rdata_q;
      r1_err_d   = r1_err_q;
    end
  end

  // All state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      lock_cnt_q  <= 8'd0;
      r0_rvalid_q <= 1'b0;
      r0_rdata_q  <= 32'h0000_0000;
      r0_err_q    <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r1_rdata_q  <= 32'h0000_0000;
      r1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r0_err_q    <= r0_err_d;
      r1_rvalid_q <= r1_rvalid_d;
      r1_rdata_q  <= r1_rdata_d;
      r1_err_q    <= r1_err_d;
    end
  end

  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r0_err    = r0_err_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r1_rdata  = r1_rdata_q;
  assign bus.r1_err    = r1_err_q;

endmodule

// File: tb/tb_mem_b_port_arbiter.sv
// Self-checking bench for mem_b_port_arbiter: byte-lane memory model behind port B, a reference
// byte array predicting every response, and per-port scoreboards of expected {err, rdata}.
module tb_mem_b_port_arbiter;
  logic        clk;
  logic        rst;
  int          n_cmp;
  int          n_bad;
  logic [32:0] sb0[$];
  logic [32:0] sb1[$];
  logic [7:0]  ref_mem [0:1023];
  logic [7:0]  mem [0:1023];
  logic [9:0]  rd_ix;
  logic        g0, g1, rv0, rv1, e0, e1;
  logic [3:0]  ms;
  logic [31:0] ma, rd0, rd1;

  mem_b_port_arbiter_if bus ();

  mem_b_port_arbiter #(.MEM_BYTES(1024), .MAX_LOCK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind port B: byte-strobed writes on the edge, combinational read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_start[i]) mem[bus.mem_addr[9:0] + 10'(i)] <= bus.mem_write[8*i +: 8];
    end
  end

  always_comb begin
    rd_ix        = bus.mem_addr[9:0];
    bus.mem_read = {mem[rd_ix + 10'd3], mem[rd_ix + 10'd2], mem[rd_ix + 10'd1], mem[rd_ix]};
  end

  // Reference access: legal iff the whole word fits (addr+3 <= 1023); returns pre-write data.
  task automatic model_access(input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wd, output logic [32:0] resp);
    logic [9:0] ix;
    if (addr > 32'd1020) begin
      resp = {1'b1, 32'h0000_0000};
    end else begin
      ix   = addr[9:0];
      resp = {1'b0, ref_mem[ix + 10'd3], ref_mem[ix + 10'd2], ref_mem[ix + 10'd1], ref_mem[ix]};
      for (int i = 0; i < 4; i++) if (strb[i]) ref_mem[ix + 10'(i)] = wd[8*i +: 8];
    end
  endtask

  // Drive one cycle of requests, sample grant-side outputs mid-cycle and return-side after the edge.
  task automatic cycle(input logic q0, input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk);
    bus.r0_req = q0; bus.r0_start = s0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_req = q1; bus.r1_start = s1; bus.r1_addr = a1; bus.r1_wdata = d1;
    bus.r1_lock = lk;
    #1;
    g0 = bus.r0_gnt; g1 = bus.r1_gnt; ms = bus.mem_start; ma = bus.mem_addr;
    @(posedge clk); #1;
    rv0 = bus.r0_rvalid; rd0 = bus.r0_rdata; e0 = bus.r0_err;
    rv1 = bus.r1_rvalid; rd1 = bus.r1_rdata; e1 = bus.r1_err;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'hF, 32'h10, 32'h5555_5555, 1'b1, 4'hF, 32'h14, 32'h6666_6666, 1'b1);
      n_cmp++;
      if (g0 !== 1'b0 || g1 !== 1'b0) begin
        n_bad++; $display("FAIL reset.gnt cyc%0d: got %b%b want 00", i, g0, g1);
      end
      n_cmp++;
      if (ms !== 4'h0) begin n_bad++; $display("FAIL reset.mem_start: got %h want 0", ms); end
      n_cmp++;
      if ({rv0, rv1} !== 2'b00) begin n_bad++; $display("FAIL reset.rvalid: got %b%b want 00", rv0, rv1); end
      n_cmp++;
      if ({e0, e1} !== 2'b00 || rd0 !== 32'h0 || rd1 !== 32'h0) begin
        n_bad++; $display("FAIL reset.rdata_err: got %h/%b %h/%b want 0", rd0, e0, rd1, e1);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask

  // r0 alone: write then immediate read of the same word, then an idle cycle.
  task automatic test_r0_rw();
    logic [3:0]  st [3];
    logic [31:0] ad [3];
    logic [31:0] dt [3];
    logic [32:0] want;
    st = '{4'hF, 4'h0, 4'h0};
    ad = '{32'h10, 32'h10, 32'h10};
    dt = '{32'hDEAD_BEEF, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        model_access(ad[i], st[i], dt[i], want);
        sb0.push_back(want);
        cycle(1'b1, st[i], ad[i], dt[i], 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        n_cmp++;
        if (g0 !== 1'b1 || g1 !== 1'b0 || ma !== ad[i] || ms !== st[i]) begin
          n_bad++; $display("FAIL rw.grant op%0d: got g=%b%b addr=%h strb=%h want g=10 addr=%h strb=%h",
                            i, g0, g1, ma, ms, ad[i], st[i]);
        end
      end else begin
        cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      end
      n_cmp++;
      if (rv0 !== (sb0.size() != 0)) begin
        n_bad++; $display("FAIL rw.r0_rvalid op%0d: got %b want %b", i, rv0, sb0.size() != 0);
        if (sb0.size() != 0) want = sb0.pop_front();
      end else if (rv0) begin
        want = sb0.pop_front();
        n_cmp++;
        if ({e0, rd0} !== want) begin
          n_bad++; $display("FAIL rw.r0_resp op%0d: got err=%b data=%h want err=%b data=%h",
                            i, e0, rd0, want[32], want[31:0]);
        end
      end
      n_cmp++;
      if (rv1 !== 1'b0) begin n_bad++; $display("FAIL rw.r1_rvalid: got %b want 0", rv1); end
    end
  endtask

  // Both requesters continuously: r0 reads 0x100, r1 writes it; grants must alternate r0 first.
  task automatic test_alternate();
    logic [32:0] want;
    logic        exp0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        exp0 = (i % 2 == 0);
        if (exp0) begin
          model_access(32'h100, 4'h0, 32'h0, want); sb0.push_back(want);
        end else begin
          model_access(32'h100, 4'hF, 32'hA000_0000 + 32'(i | 1), want); sb1.push_back(want);
        end
        cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'hF, 32'h100, 32'hA000_0000 + 32'(i | 1), 1'b0);
        n_cmp++;
        if (g0 !== exp0 || g1 !== !exp0) begin
          n_bad++; $display("FAIL alt.gnt cyc%0d: got %b%b want %b%b", i, g0, g1, exp0, !exp0);
        end
      end else begin
        cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      end
      n_cmp++;
      if (rv0 !== (sb0.size() != 0) || rv1 !== (sb1.size() != 0)) begin
        n_bad++; $display("FAIL alt.rvalid cyc%0d: got %b%b want %b%b", i, rv0, rv1, sb0.size() != 0, sb1.size() != 0);
        sb0.delete(); sb1.delete();
      end else begin
        if (rv0) begin
          want = sb0.pop_front(); n_cmp++;
          if ({e0, rd0} !== want) begin
            n_bad++; $display("FAIL alt.r0_resp cyc%0d: got %b/%h want %b/%h", i, e0, rd0, want[32], want[31:0]);
          end
        end
        if (rv1) begin
          want = sb1.pop_front(); n_cmp++;
          if ({e1, rd1} !== want) begin
            n_bad++; $display("FAIL alt.r1_resp cyc%0d: got %b/%h want %b/%h", i, e1, rd1, want[32], want[31:0]);
          end
        end
      end
    end
  endtask

  // r1 locked reads with r0 waiting: after the IDLE entry grant r1 holds 16 more grants,
  // then r0 gets exactly one, then r1 re-enters a fresh lock.
  task automatic test_lock();
    logic [32:0] want;
    logic        exp0;
    logic [31:0] r0d;
    do_reset();
    r0d = 32'hC0DE_0000;
    for (int i = 0; i < 41; i++) begin
      if (i < 40) begin
        exp0 = (i == 0) || ((i - 1) % 18 == 17);
        if (exp0) begin
          model_access(32'h200, 4'hF, r0d, want); sb0.push_back(want);
        end else begin
          model_access(32'h200, 4'h0, 32'h0, want); sb1.push_back(want);
        end
        cycle(1'b1, 4'hF, 32'h200, r0d, 1'b1, 4'h0, 32'h200, 32'h0, 1'b1);
        if (exp0) r0d = r0d + 32'd1;
        n_cmp++;
        if (g0 !== exp0 || g1 !== !exp0) begin
          n_bad++; $display("FAIL lock.gnt cyc%0d: got %b%b want %b%b", i, g0, g1, exp0, !exp0);
        end
      end else begin
        cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      end
      n_cmp++;
      if (rv0 !== (sb0.size() != 0) || rv1 !== (sb1.size() != 0)) begin
        n_bad++; $display("FAIL lock.rvalid cyc%0d: got %b%b want %b%b", i, rv0, rv1, sb0.size() != 0, sb1.size() != 0);
        sb0.delete(); sb1.delete();
      end else begin
        if (rv0) begin
          want = sb0.pop_front(); n_cmp++;
          if ({e0, rd0} !== want) begin
            n_bad++; $display("FAIL lock.r0_resp cyc%0d: got %b/%h want %b/%h", i, e0, rd0, want[32], want[31:0]);
          end
        end
        if (rv1) begin
          want = sb1.pop_front(); n_cmp++;
          if ({e1, rd1} !== want) begin
            n_bad++; $display("FAIL lock.r1_resp cyc%0d: got %b/%h want %b/%h", i, e1, rd1, want[32], want[31:0]);
          end
        end
      end
    end
  endtask

  // Partial byte-lane write over a full word.
  task automatic test_strobe();
    logic [3:0]  st [3];
    logic [31:0] dt [3];
    logic [32:0] want;
    st = '{4'hF, 4'b0101, 4'h0};
    dt = '{32'hAAAA_AAAA, 32'h1122_3344, 32'h0};
    for (int i = 0; i < 3; i++) begin
      model_access(32'h20, st[i], dt[i], want);
      sb0.push_back(want);
      cycle(1'b1, st[i], 32'h20, dt[i], 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      n_cmp++;
      if (g0 !== 1'b1 || ms !== st[i]) begin
        n_bad++; $display("FAIL strobe.grant op%0d: got g0=%b strb=%h want 1/%h", i, g0, ms, st[i]);
      end
      n_cmp++;
      if (rv0 !== 1'b1) begin
        n_bad++; $display("FAIL strobe.rvalid op%0d: got %b want 1", i, rv0);
        sb0.delete();
      end else begin
        want = sb0.pop_front(); n_cmp++;
        if ({e0, rd0} !== want) begin
          n_bad++; $display("FAIL strobe.resp op%0d: got %b/%h want %b/%h", i, e0, rd0, want[32], want[31:0]);
        end
      end
    end
    n_cmp++;
    if (rd0 !== 32'hAA22_AA44) begin
      n_bad++; $display("FAIL strobe.merge: got %h want aa22aa44", rd0);
    end
  endtask

  // r1 range check around the top of memory and a wrapped address.
  task automatic test_range();
    logic [3:0]  st [6];
    logic [31:0] ad [6];
    logic [31:0] dt [6];
    logic [32:0] want;
    logic [3:0]  exp_ms;
    st = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    ad = '{32'h3FD, 32'h3FC, 32'h3FC, 32'h3FC, 32'hFFFF_FFFE, 32'h0};
    dt = '{32'h1234_5678, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      exp_ms = (ad[i] > 32'd1020) ? 4'h0 : st[i];
      model_access(ad[i], st[i], dt[i], want);
      sb1.push_back(want);
      cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, st[i], ad[i], dt[i], 1'b0);
      n_cmp++;
      if (g1 !== 1'b1 || g0 !== 1'b0 || ms !== exp_ms) begin
        n_bad++; $display("FAIL range.grant op%0d: got g=%b%b strb=%h want g=01 strb=%h", i, g0, g1, ms, exp_ms);
      end
      n_cmp++;
      if (rv1 !== 1'b1) begin
        n_bad++; $display("FAIL range.rvalid op%0d: got %b want 1", i, rv1);
        sb1.delete();
      end else begin
        want = sb1.pop_front(); n_cmp++;
        if ({e1, rd1} !== want) begin
          n_bad++; $display("FAIL range.resp op%0d: got err=%b data=%h want err=%b data=%h",
                            i, e1, rd1, want[32], want[31:0]);
        end
      end
    end
  endtask

  // Reset while r1 holds a lock: grants suppressed, nothing returned, arbitration restarts with r0.
  task automatic test_reset_lock();
    logic [32:0] want;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      model_access(32'h40, 4'h0, 32'h0, want); sb1.push_back(want);
      cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
      n_cmp++;
      if (g1 !== 1'b1 || rv1 !== 1'b1) begin
        n_bad++; $display("FAIL rstlock.pre cyc%0d: got g1=%b rv1=%b want 1/1", i, g1, rv1);
        sb1.delete();
      end else begin
        want = sb1.pop_front();
        n_cmp++;
        if ({e1, rd1} !== want) begin
          n_bad++; $display("FAIL rstlock.pre_resp: got %b/%h want %b/%h", e1, rd1, want[32], want[31:0]);
        end
      end
    end
    rst = 1'b1;
    cycle(1'b1, 4'hF, 32'h44, 32'h7777_7777, 1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    n_cmp++;
    if (g0 !== 1'b0 || g1 !== 1'b0 || ms !== 4'h0) begin
      n_bad++; $display("FAIL rstlock.gnt_in_rst: got g=%b%b strb=%h want 00/0", g0, g1, ms);
    end
    n_cmp++;
    if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
      n_bad++; $display("FAIL rstlock.rvalid_dropped: got %b%b want 00", rv0, rv1);
    end
    model_access(32'h44, 4'h0, 32'h0, want); sb0.push_back(want);
    cycle(1'b1, 4'h0, 32'h44, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b1);
    n_cmp++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      n_bad++; $display("FAIL rstlock.first_gnt: got %b%b want 10", g0, g1);
    end
    n_cmp++;
    if (rv0 !== 1'b1 || rv1 !== 1'b0) begin
      n_bad++; $display("FAIL rstlock.post_rvalid: got %b%b want 10", rv0, rv1);
      sb0.delete();
    end else begin
      want = sb0.pop_front();
      n_cmp++;
      if ({e0, rd0} !== want) begin
        n_bad++; $display("FAIL rstlock.post_resp: got %b/%h want %b/%h", e0, rd0, want[32], want[31:0]);
      end
    end
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    test_reset();
    test_r0_rw();
    test_alternate();
    test_lock();
    test_strobe();
    test_range();
    test_reset_lock();
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d/%0d pending want 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
